dcache_mem_adapter: RTL and testbench

DCACHE_MEM_ADAPTER -- requirements
Module: dcache_mem_adapter

---
 rtl/dcache_mem_adapter_pkg.sv | 30 +++
 rtl/dcache_ports_if.sv | 24 ++
 rtl/mem_bus_if.sv | 21 ++
 rtl/dcache_mem_align.sv | 21 ++
 rtl/dcache_mem_adapter.sv | 106 ++++++++++
 tb/tb_dcache_mem_adapter.sv | 294 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/dcache_mem_adapter_pkg.sv
// Shared core types for the data-cache to 64-bit memory adapter:
// access sizes, the adapter FSM states and size-derived masks.
package dcache_mem_adapter_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} inst_size_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} adapter_state_e;

  function automatic logic [7:0] size_strb(input inst_size_t s);
    logic [7:0] m;
    unique case (s)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] size_dmask(input inst_size_t s);
    logic [XLEN-1:0] m;
    unique case (s)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/dcache_ports_if.sv
// Data-cache side of the adapter: store write port plus load request/response.
interface dcache_ports_if;
  import dcache_mem_adapter_pkg::*;
  logic [XLEN-1:0] waddr;
  inst_size_t      wsize;
  logic [XLEN-1:0] wdata;
  logic            wvalid;
  logic            wready;
  logic [XLEN-1:0] load_a_addr;
  inst_size_t      load_a_size;
  logic            load_a_valid;
  logic            load_a_ready;
  logic [XLEN-1:0] load_d_data;
  logic            load_d_valid;

  modport slave (
    input  waddr, wsize, wdata, wvalid, load_a_addr, load_a_size, load_a_valid,
    output wready, load_a_ready, load_d_data, load_d_valid
  );
  modport master (
    output waddr, wsize, wdata, wvalid, load_a_addr, load_a_size, load_a_valid,
    input  wready, load_a_ready, load_d_data, load_d_valid
  );
endinterface

// File: rtl/mem_bus_if.sv
// Single-outstanding 64-bit memory bus: request channel plus response channel.
interface mem_bus_if;
  import dcache_mem_adapter_pkg::*;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [63:0]     mem_req_wdata;
  logic [7:0]      mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [63:0]     mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/dcache_mem_align.sv
// Lane alignment shared by both paths: store strobe/data placement and
// load extraction (right-align, zero-extend to the access size).
module dcache_mem_align
  import dcache_mem_adapter_pkg::*;
(
  input  inst_size_t      size_i,
  input  logic [2:0]      offset_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [7:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);
  logic [5:0] bit_sh;

  assign bit_sh  = {offset_i, 3'b000};
  // Boundary-crossing bytes fall off the top of the 8-bit strobe.
  assign wstrb_o = size_strb(size_i) << offset_i;
  assign wdata_o = wdata_i << bit_sh;
  assign rdata_o = (rdata_i >> bit_sh) & size_dmask(size_i);
endmodule

// File: rtl/dcache_mem_adapter.sv
// Bridges dcache stores/loads onto a 64-bit memory bus, one transaction at
// a time; stores win same-cycle ties since the committed store is older.
module dcache_mem_adapter
  import dcache_mem_adapter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dcache_ports_if.slave dcache_ports_io,
  mem_bus_if.master     mem_bus_io
);
  adapter_state_e  state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
  inst_size_t      size_q, size_d;
  logic            we_q, we_d;
  logic            ld_vld_q, ld_vld_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic [31:0]     perf_cnt_q, perf_cnt_d;
  logic            idle, st_acc, ld_acc;
  logic [7:0]      al_strb;
  logic [XLEN-1:0] al_wdata, al_rdata;

  assign idle   = (state_q == IDLE) && !rst;
  assign st_acc = idle && dcache_ports_io.wvalid;
  assign ld_acc = idle && !dcache_ports_io.wvalid && dcache_ports_io.load_a_valid;

  dcache_mem_align u_align (
    .size_i  (size_q),
    .offset_i(addr_q[2:0]),
    .wdata_i (data_q),
    .rdata_i (mem_bus_io.mem_rsp_rdata),
    .wstrb_o (al_strb),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    we_d       = we_q;
    data_d     = data_q;
    ld_vld_d   = 1'b0;
    ld_data_d  = ld_data_q;
    perf_cnt_d = perf_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (st_acc) begin
          addr_d  = dcache_ports_io.waddr;
          size_d  = dcache_ports_io.wsize;
          data_d  = dcache_ports_io.wdata;
          we_d    = 1'b1;
          state_d = REQ;
        end else if (ld_acc) begin
          addr_d  = dcache_ports_io.load_a_addr;
          size_d  = dcache_ports_io.load_a_size;
          data_d  = '0;
          we_d    = 1'b0;
          state_d = REQ;
        end
      end
      REQ: if (mem_bus_io.mem_req_ready) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (mem_bus_io.mem_rsp_valid) begin
          state_d  = IDLE;
          ld_vld_d = !we_q;
          if (!we_q) ld_data_d = al_rdata;
          if (perf_cnt_q != '1) perf_cnt_d = perf_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= SZ_B;
      we_q       <= 1'b0;
      data_q     <= '0;
      ld_vld_q   <= 1'b0;
      ld_data_q  <= '0;
      perf_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      we_q       <= we_d;
      data_q     <= data_d;
      ld_vld_q   <= ld_vld_d;
      ld_data_q  <= ld_data_d;
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign dcache_ports_io.wready       = idle;
  assign dcache_ports_io.load_a_ready = idle && !dcache_ports_io.wvalid;
  assign dcache_ports_io.load_d_valid = ld_vld_q && !rst;
  assign dcache_ports_io.load_d_data  = rst ? '0 : ld_data_q;

  assign mem_bus_io.mem_req_valid = (state_q == REQ) && !rst;
  assign mem_bus_io.mem_req_we    = we_q;
  assign mem_bus_io.mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign mem_bus_io.mem_req_wstrb = we_q ? al_strb : 8'h00;
  assign mem_bus_io.mem_req_wdata = al_wdata;
endmodule

// File: tb/tb_dcache_mem_adapter.sv
// Scoreboard bench: expected memory requests and load data are queued when
// stimulus is driven and compared when the adapter emits them.
module tb_dcache_mem_adapter;
  import dcache_mem_adapter_pkg::*;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } mreq_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ports_if dc();
  mem_bus_if      mb();

  dcache_mem_adapter dut (
    .clk            (clk),
    .rst            (rst),
    .dcache_ports_io(dc.slave),
    .mem_bus_io     (mb.master)
  );

  int          n_chk = 0, n_pass = 0, cyc = 0, stall_left = 0, n_txn = 0;
  logic        rsp_next = 1'b0, rsp_en = 1'b1, inject_rsp = 1'b0;
  logic [63:0] mem_rdata = '0;
  mreq_t       exp_req[$];
  logic [63:0] exp_ld[$];
  int          ld_cyc_log[$];

  function automatic logic crosses(input logic [2:0] off, input inst_size_t s);
    return (int'(off) + (1 << int'(s))) > 8;
  endfunction

  always @(posedge clk) begin
    if (!rst && dc.wvalid && dc.wready)
      assert (!crosses(dc.waddr[2:0], dc.wsize)) else $error("store crosses 8-byte line");
    if (!rst && dc.load_a_valid && dc.load_a_ready)
      assert (!crosses(dc.load_a_addr[2:0], dc.load_a_size)) else $error("load crosses 8-byte line");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  function automatic logic [7:0] m_strb(input logic [2:0] off, input inst_size_t s);
    logic [7:0] r = '0;
    for (int i = 0; i < (1 << int'(s)); i++)
      if (int'(off) + i < 8) r[int'(off) + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] d, input logic [2:0] off,
                                         input inst_size_t s);
    logic [63:0] r = '0;
    for (int i = 0; i < (1 << int'(s)); i++)
      if (int'(off) + i < 8) r[i*8 +: 8] = d[(int'(off) + i)*8 +: 8];
    return r;
  endfunction

  // One clock: monitor load responses, then play the memory for the next edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (dc.load_d_valid) begin
      ld_cyc_log.push_back(cyc);
      if (exp_ld.size() > 0) chk("ld_data", dc.load_d_data, exp_ld.pop_front());
      else chk("ld_spurious", 64'(dc.load_d_valid), 64'd0);
    end
    mb.mem_rsp_valid = 1'b0;
    if (rsp_next) begin
      mb.mem_rsp_valid = 1'b1;
      mb.mem_rsp_rdata = mem_rdata;
      rsp_next = 1'b0;
      n_txn++;
    end else if (inject_rsp) begin
      mb.mem_rsp_valid = 1'b1;
      mb.mem_rsp_rdata = ~mem_rdata;
      inject_rsp = 1'b0;
    end
    mb.mem_req_ready = 1'b1;
    if (mb.mem_req_valid) begin
      if (stall_left > 0) begin
        mb.mem_req_ready = 1'b0;
        stall_left--;
        if (exp_req.size() > 0) begin
          chk("stall_addr", mb.mem_req_addr, exp_req[0].addr);
          chk("stall_strb", 64'(mb.mem_req_wstrb), 64'(exp_req[0].strb));
          chk("stall_we", 64'(mb.mem_req_we), 64'(exp_req[0].we));
        end
        chk("stall_wready", 64'(dc.wready), 64'd0);
        chk("stall_lar", 64'(dc.load_a_ready), 64'd0);
      end else if (exp_req.size() == 0) begin
        chk("req_spurious", 64'(mb.mem_req_valid), 64'd0);
      end else begin
        mreq_t e;
        e = exp_req.pop_front();
        chk("req_addr", mb.mem_req_addr, e.addr);
        chk("req_we", 64'(mb.mem_req_we), 64'(e.we));
        chk("req_strb", 64'(mb.mem_req_wstrb), 64'(e.strb));
        if (e.we) chk("req_wdata", mb.mem_req_wdata, e.wdata);
        rsp_next = rsp_en;
      end
    end
  endtask

  task automatic issue_store(input logic [63:0] a, input inst_size_t s, input logic [63:0] d);
    int n = 0;
    dc.waddr = a; dc.wsize = s; dc.wdata = d; dc.wvalid = 1'b1;
    #1;
    while (!dc.wready && n < 40) begin tick(); #1; n++; end
    chk("st_accept", 64'(dc.wready), 64'd1);
    tick();
    dc.wvalid = 1'b0;
  endtask

  task automatic issue_load(input logic [63:0] a, input inst_size_t s);
    int n = 0;
    dc.load_a_addr = a; dc.load_a_size = s; dc.load_a_valid = 1'b1;
    #1;
    while (!dc.load_a_ready && n < 40) begin tick(); #1; n++; end
    chk("ld_accept", 64'(dc.load_a_ready), 64'd1);
    tick();
    dc.load_a_valid = 1'b0;
  endtask

  task automatic push_store(input logic [63:0] a, input inst_size_t s, input logic [63:0] d);
    exp_req.push_back('{{a[63:3], 3'b000}, 1'b1, m_strb(a[2:0], s), d << (8 * a[2:0])});
  endtask

  task automatic push_load(input logic [63:0] a, input inst_size_t s);
    exp_req.push_back('{{a[63:3], 3'b000}, 1'b0, 8'h00, 64'd0});
    exp_ld.push_back(m_load(mem_rdata, a[2:0], s));
  endtask

  task automatic drain();
    int n = 0;
    logic done;
    done = 1'b0;
    while (!done && n < 40) begin
      tick(); #1; n++;
      done = dc.wready && !rsp_next && exp_req.size() == 0 && exp_ld.size() == 0;
    end
    chk("drain", 64'(done), 64'd1);
  endtask

  logic [63:0] st_a[4] = '{64'h100B, 64'h2206, 64'h3000, 64'h4001};
  inst_size_t  st_s[4] = '{SZ_B, SZ_H, SZ_D, SZ_B};
  logic [63:0] st_d[4] = '{64'hFFAB, 64'hBEEF, 64'h0123456789ABCDEF, 64'h5A};
  logic [63:0] ld_a[4] = '{64'h5004, 64'h5000, 64'h5005, 64'h5006};
  inst_size_t  ld_s[4] = '{SZ_W, SZ_D, SZ_B, SZ_H};

  initial begin
    int acc0, n;
    rst = 1'b1;
    dc.waddr = '0; dc.wsize = SZ_B; dc.wdata = '0; dc.wvalid = 1'b0;
    dc.load_a_addr = '0; dc.load_a_size = SZ_B; dc.load_a_valid = 1'b0;
    mb.mem_req_ready = 1'b1; mb.mem_rsp_valid = 1'b0; mb.mem_rsp_rdata = '0;
    tick(); tick();
    chk("rst_wready", 64'(dc.wready), 64'd0);
    chk("rst_lar", 64'(dc.load_a_ready), 64'd0);
    chk("rst_mreq", 64'(mb.mem_req_valid), 64'd0);
    chk("rst_ldv", 64'(dc.load_d_valid), 64'd0);
    chk("rst_ldd", dc.load_d_data, 64'd0);
    chk("rst_cnt", 64'(dut.perf_cnt_q), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0;
    tick();
    chk("rel_wready", 64'(dc.wready), 64'd1);
    chk("rel_lar", 64'(dc.load_a_ready), 64'd1);

    // Reference store and load vectors with literal expectations.
    exp_req.push_back('{64'h1000, 1'b1, 8'hF0, 64'hDEADBEEF_00000000});
    issue_store(64'h1004, SZ_W, 64'hDEADBEEF);
    drain();
    mem_rdata = 64'h1122334455667788;
    exp_req.push_back('{64'h2000, 1'b0, 8'h00, 64'd0});
    exp_ld.push_back(64'h5566);
    issue_load(64'h2002, SZ_H);
    drain();
    tick(); tick(); tick();
    chk("ld_hold", dc.load_d_data, 64'h5566);

    for (int i = 0; i < 4; i++) begin
      push_store(st_a[i], st_s[i], st_d[i]);
      issue_store(st_a[i], st_s[i], st_d[i]);
      drain();
    end
    mem_rdata = 64'h0123456789ABCDEF;
    for (int i = 0; i < 4; i++) begin
      push_load(ld_a[i], ld_s[i]);
      issue_load(ld_a[i], ld_s[i]);
      drain();
    end

    // Same-cycle store and load: store goes first, load waits for its response.
    push_store(64'h3008, SZ_D, 64'h0102030405060708);
    push_load(64'h3014, SZ_W);
    dc.waddr = 64'h3008; dc.wsize = SZ_D; dc.wdata = 64'h0102030405060708; dc.wvalid = 1'b1;
    dc.load_a_addr = 64'h3014; dc.load_a_size = SZ_W; dc.load_a_valid = 1'b1;
    #1;
    chk("tie_lar", 64'(dc.load_a_ready), 64'd0);
    chk("tie_wready", 64'(dc.wready), 64'd1);
    acc0 = cyc + 1;
    tick();
    dc.wvalid = 1'b0;
    #1;
    n = 0;
    while (!dc.load_a_ready && n < 40) begin tick(); #1; n++; end
    chk("tie_ld_cyc", 64'(cyc), 64'(acc0 + 2));
    tick();
    dc.load_a_valid = 1'b0;
    drain();

    // Held-off request with a stray response while still in REQ.
    stall_left = 5;
    push_load(64'h6003, SZ_B);
    issue_load(64'h6003, SZ_B);
    inject_rsp = 1'b1;
    drain();
    chk("stall_done", 64'(stall_left), 64'd0);

    inject_rsp = 1'b1;
    tick(); tick();
    chk("idle_rsp_state", 64'(dut.state_q), 64'(IDLE));
    chk("idle_rsp_ldd", dc.load_d_data, m_load(64'h0123456789ABCDEF, 3'd3, SZ_B));

    // Back-to-back byte loads, memory answering immediately.
    mem_rdata = 64'hA1B2C3D4E5F60718;
    push_load(64'h7, SZ_B);
    push_load(64'h0, SZ_B);
    ld_cyc_log.delete();
    dc.load_a_addr = 64'h7; dc.load_a_size = SZ_B; dc.load_a_valid = 1'b1;
    acc0 = cyc + 1;
    tick();
    dc.load_a_addr = 64'h0;
    #1;
    n = 0;
    while (!dc.load_a_ready && n < 40) begin tick(); #1; n++; end
    tick();
    dc.load_a_valid = 1'b0;
    drain();
    chk("b2b_cnt", 64'(ld_cyc_log.size()), 64'd2);
    if (ld_cyc_log.size() == 2) begin
      chk("b2b_first", 64'(ld_cyc_log[0]), 64'(acc0 + 2));
      chk("b2b_second", 64'(ld_cyc_log[1]), 64'(acc0 + 5));
    end
    chk("perf_cnt", 64'(dut.perf_cnt_q), 64'(n_txn));

    // Reset while waiting on memory; the late response must be dropped.
    rsp_en = 1'b0;
    exp_req.push_back('{64'h8000, 1'b0, 8'h00, 64'd0});
    issue_load(64'h8000, SZ_D);
    tick();
    chk("mid_state", 64'(dut.state_q), 64'(WAIT_RSP));
    rst = 1'b1;
    #1;
    chk("mid_rst_wready", 64'(dc.wready), 64'd0);
    chk("mid_rst_lar", 64'(dc.load_a_ready), 64'd0);
    tick();
    n_txn = 0;
    chk("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
    chk("mid_rst_ldd", dc.load_d_data, 64'd0);
    chk("mid_rst_cnt", 64'(dut.perf_cnt_q), 64'd0);
    rst = 1'b0;
    rsp_en = 1'b1;
    tick();
    chk("mid_rel_wready", 64'(dc.wready), 64'd1);
    inject_rsp = 1'b1;
    tick(); tick(); tick();
    chk("stale_state", 64'(dut.state_q), 64'(IDLE));
    chk("stale_ldv_log", 64'(ld_cyc_log.size()), 64'd2);

    push_load(64'h9002, SZ_H);
    issue_load(64'h9002, SZ_H);
    drain();
    chk("perf_cnt_post", 64'(dut.perf_cnt_q), 64'(n_txn));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
